// File: rtl/dcache_mem_arbiter.sv
// Two-master to one-slave memory arbiter for the data cache: independent read and write
// paths, each round-robin arbitrated with a single outstanding transaction.
module dcache_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int TAG_S  = 64,
  parameter int ID_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W-1:0]         m0_arid_i,
  input  logic [ADDR_W-1:0]       m0_araddr_i,
  input  logic                    m0_arvalid_i,
  output logic                    m0_arready_o,
  output logic [ID_W-1:0]         m0_rid_o,
  output logic [TAG_S+DATA_W-1:0] m0_rdata_o,
  output logic                    m0_rvalid_o,
  input  logic                    m0_rready_i,
  input  logic [ID_W-1:0]         m0_awid_i,
  input  logic [ADDR_W-1:0]       m0_awaddr_i,
  input  logic                    m0_awvalid_i,
  output logic                    m0_awready_o,
  input  logic [DATA_W-1:0]       m0_wdata_i,
  input  logic                    m0_wvalid_i,
  output logic                    m0_wready_o,
  output logic [ID_W-1:0]         m0_bid_o,
  output logic                    m0_bvalid_o,
  input  logic                    m0_bready_i,
  input  logic [ID_W-1:0]         m1_arid_i,
  input  logic [ADDR_W-1:0]       m1_araddr_i,
  input  logic                    m1_arvalid_i,
  output logic                    m1_arready_o,
  output logic [ID_W-1:0]         m1_rid_o,
  output logic [TAG_S+DATA_W-1:0] m1_rdata_o,
  output logic                    m1_rvalid_o,
  input  logic                    m1_rready_i,
  input  logic [ID_W-1:0]         m1_awid_i,
  input  logic [ADDR_W-1:0]       m1_awaddr_i,
  input  logic                    m1_awvalid_i,
  output logic                    m1_awready_o,
  input  logic [DATA_W-1:0]       m1_wdata_i,
  input  logic                    m1_wvalid_i,
  output logic                    m1_wready_o,
  output logic [ID_W-1:0]         m1_bid_o,
  output logic                    m1_bvalid_o,
  input  logic                    m1_bready_i,
  output logic [ID_W-1:0]         s_arid_o,
  output logic [ADDR_W-1:0]       s_araddr_o,
  output logic                    s_arvalid_o,
  input  logic                    s_arready_i,
  input  logic [ID_W-1:0]         s_rid_i,
  input  logic [TAG_S+DATA_W-1:0] s_rdata_i,
  input  logic                    s_rvalid_i,
  output logic                    s_rready_o,
  output logic [ID_W-1:0]         s_awid_o,
  output logic [ADDR_W-1:0]       s_awaddr_o,
  output logic                    s_awvalid_o,
  input  logic                    s_awready_i,
  output logic [ID_W-1:0]         s_wid_o,
  output logic [DATA_W-1:0]       s_wdata_o,
  output logic                    s_wvalid_o,
  input  logic                    s_wready_i,
  input  logic [ID_W-1:0]         s_bid_i,
  input  logic                    s_bvalid_i,
  output logic                    s_bready_o
);

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wr_state_e;

  rd_state_e         rd_state_q, rd_state_d;
  logic              rd_owner_q, rd_owner_d, rd_last_q, rd_last_d, rd_win;
  logic [ID_W-1:0]   rd_id_q, rd_id_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  wr_state_e         wr_state_q, wr_state_d;
  logic              wr_owner_q, wr_owner_d, wr_last_q, wr_last_d, wr_win;
  logic [ID_W-1:0]   wr_id_q, wr_id_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;

  logic [1:0] arvalid, arready, rvalid, rready;
  logic [1:0] awvalid, awready, wvalid, wready, bvalid, bready;

  assign arvalid = {m1_arvalid_i, m0_arvalid_i};
  assign rready  = {m1_rready_i,  m0_rready_i};
  assign awvalid = {m1_awvalid_i, m0_awvalid_i};
  assign wvalid  = {m1_wvalid_i,  m0_wvalid_i};
  assign bready  = {m1_bready_i,  m0_bready_i};

  // A lone requester wins; on a tie the master not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  assign rd_win = rr_pick(arvalid, rd_last_q);
  assign wr_win = rr_pick(awvalid, wr_last_q);

  always_comb begin
    rd_state_d  = rd_state_q;
    rd_owner_d  = rd_owner_q;
    rd_last_d   = rd_last_q;
    rd_id_d     = rd_id_q;
    rd_addr_d   = rd_addr_q;
    arready     = '0;
    rvalid      = '0;
    s_arvalid_o = 1'b0;
    s_rready_o  = 1'b0;
    case (rd_state_q)
      R_IDLE: if (|arvalid) begin
        arready[rd_win] = 1'b1;
        rd_owner_d      = rd_win;
        rd_last_d       = rd_win;
        rd_id_d         = rd_win ? m1_arid_i : m0_arid_i;
        rd_addr_d       = rd_win ? m1_araddr_i : m0_araddr_i;
        rd_state_d      = R_ADDR;
      end
      R_ADDR: begin
        s_arvalid_o = 1'b1;
        if (s_arready_i) rd_state_d = R_DATA;
      end
      R_DATA: begin
        rvalid[rd_owner_q] = s_rvalid_i;
        s_rready_o         = rready[rd_owner_q];
        if (s_rvalid_i && rready[rd_owner_q]) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
    // Handshake outputs stay quiet while reset is held, whatever the state.
    if (!rst_n) begin
      arready     = '0;
      rvalid      = '0;
      s_arvalid_o = 1'b0;
      s_rready_o  = 1'b0;
    end
  end

  always_comb begin
    wr_state_d  = wr_state_q;
    wr_owner_d  = wr_owner_q;
    wr_last_d   = wr_last_q;
    wr_id_d     = wr_id_q;
    wr_addr_d   = wr_addr_q;
    awready     = '0;
    wready      = '0;
    bvalid      = '0;
    s_awvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    s_bready_o  = 1'b0;
    case (wr_state_q)
      W_IDLE: if (|awvalid) begin
        awready[wr_win] = 1'b1;
        wr_owner_d      = wr_win;
        wr_last_d       = wr_win;
        wr_id_d         = wr_win ? m1_awid_i : m0_awid_i;
        wr_addr_d       = wr_win ? m1_awaddr_i : m0_awaddr_i;
        wr_state_d      = W_ADDR;
      end
      W_ADDR: begin
        s_awvalid_o = 1'b1;
        if (s_awready_i) wr_state_d = W_DATA;
      end
      W_DATA: begin
        s_wvalid_o         = wvalid[wr_owner_q];
        wready[wr_owner_q] = s_wready_i;
        if (wvalid[wr_owner_q] && s_wready_i) wr_state_d = W_RESP;
      end
      W_RESP: begin
        bvalid[wr_owner_q] = s_bvalid_i;
        s_bready_o         = bready[wr_owner_q];
        if (s_bvalid_i && bready[wr_owner_q]) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
    if (!rst_n) begin
      awready     = '0;
      wready      = '0;
      bvalid      = '0;
      s_awvalid_o = 1'b0;
      s_wvalid_o  = 1'b0;
      s_bready_o  = 1'b0;
    end
  end

  // Last-grant pointers reset to M1 so M0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_state_q <= R_IDLE;
      rd_owner_q <= 1'b0;
      rd_last_q  <= 1'b1;
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      wr_state_q <= W_IDLE;
      wr_owner_q <= 1'b0;
      wr_last_q  <= 1'b1;
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_owner_q <= rd_owner_d;
      rd_last_q  <= rd_last_d;
      rd_id_q    <= rd_id_d;
      rd_addr_q  <= rd_addr_d;
      wr_state_q <= wr_state_d;
      wr_owner_q <= wr_owner_d;
      wr_last_q  <= wr_last_d;
      wr_id_q    <= wr_id_d;
      wr_addr_q  <= wr_addr_d;
    end
  end

  assign m0_arready_o = arready[0];
  assign m1_arready_o = arready[1];
  assign m0_rvalid_o  = rvalid[0];
  assign m1_rvalid_o  = rvalid[1];
  assign m0_rid_o     = s_rid_i;
  assign m1_rid_o     = s_rid_i;
  assign m0_rdata_o   = s_rdata_i;
  assign m1_rdata_o   = s_rdata_i;
  assign s_arid_o     = rd_id_q;
  assign s_araddr_o   = rd_addr_q;

  assign m0_awready_o = awready[0];
  assign m1_awready_o = awready[1];
  assign m0_wready_o  = wready[0];
  assign m1_wready_o  = wready[1];
  assign m0_bvalid_o  = bvalid[0];
  assign m1_bvalid_o  = bvalid[1];
  assign m0_bid_o     = s_bid_i;
  assign m1_bid_o     = s_bid_i;
  assign s_awid_o     = wr_id_q;
  assign s_awaddr_o   = wr_addr_q;
  assign s_wid_o      = wr_id_q;
  assign s_wdata_o    = wr_owner_q ? m1_wdata_i : m0_wdata_i;

endmodule

// File: doc/dcache_mem_arbiter.md
DCACHE_MEM_ARBITER -- requirements
Module: dcache_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 64, address width.
REQ-002 Parameter DATA_W, default 512, cache line data width.
REQ-003 Parameter TAG_S, default 64, tag word width prepended to read data.
REQ-004 Parameter ID_W, default 16, transaction ID width.
REQ-005 Port clk  in  1  clock; all logic rising-edge.
REQ-006 Port rst_n  in  1  reset, synchronous, active-low.
REQ-007 Ports mN_arid_i/mN_araddr_i/mN_arvalid_i (N=0,1)  in  ID_W/ADDR_W/1  master N read request. mN_arready_o  out  1  read request accepted.
REQ-008 Ports mN_rid_o/mN_rdata_o/mN_rvalid_o  out  ID_W/TAG_S+DATA_W/1  read response to master N. mN_rready_i  in  1  master N accepts response.
REQ-009 Ports mN_awid_i/mN_awaddr_i/mN_awvalid_i  in  ID_W/ADDR_W/1  master N write request. mN_awready_o  out  1  write request accepted.
REQ-010 Ports mN_wdata_i/mN_wvalid_i  in  DATA_W/1  master N write data. mN_wready_o  out  1  write data accepted.
REQ-011 Ports mN_bid_o/mN_bvalid_o  out  ID_W/1  write response to master N. mN_bready_i  in  1  master N accepts response.
REQ-012 Ports s_arid_o/s_araddr_o/s_arvalid_o  out, s_arready_i  in: read request to the shared memory slave.
REQ-013 Ports s_rid_i/s_rdata_i (TAG_S+DATA_W)/s_rvalid_i  in, s_rready_o  out: read response from the slave.
REQ-014 Ports s_awid_o/s_awaddr_o/s_awvalid_o/s_wid_o/s_wdata_o/s_wvalid_o/s_bready_o  out; s_awready_i/s_wready_i/s_bid_i/s_bvalid_i  in: write path to the slave.

Function
REQ-015 Read and write paths SHALL be arbitrated independently and run concurrently; each allows exactly one outstanding transaction.
REQ-016 Read FSM states SHALL be R_IDLE, R_ADDR, R_DATA.
REQ-017 R_IDLE: if any mN_arvalid_i, winner's mN_arready_o=1 combinationally, arid/araddr latched, owner recorded; -> R_ADDR next cycle.
REQ-018 R_ADDR: s_arvalid_o=1 with latched id/addr, held stable until s_arready_i=1; then -> R_DATA.
REQ-019 R_DATA: s_rdata_i/s_rid_i/s_rvalid_i passed combinationally to owner only; s_rready_o=owner mN_rready_i; on s_rvalid_i&s_rready_o -> R_IDLE.
REQ-020 Write FSM states SHALL be W_IDLE, W_ADDR, W_DATA, W_RESP.
REQ-021 W_IDLE: winner's mN_awready_o=1, awid/awaddr latched, -> W_ADDR. W_ADDR: s_awvalid_o=1 until s_awready_i, -> W_DATA.
REQ-022 W_DATA: s_wvalid_o/s_wdata_o from owner, s_wid_o=latched awid, owner mN_wready_o=s_wready_i; on handshake -> W_RESP.
REQ-023 W_RESP: s_bvalid_i/s_bid_i routed to owner, s_bready_o=owner mN_bready_i; on handshake -> W_IDLE.
REQ-024 Arbitration SHALL be round-robin per path: sole requester wins; on tie, master not granted last on that path wins; pointer updated at grant.
REQ-025 Non-owner and idle-path ready/valid outputs SHALL be 0; requests arriving while path busy wait with ready 0.
REQ-026 IDs SHALL pass unmodified; response routing by recorded owner, not ID.
REQ-027 Master-side address-to-slave latency: s_arvalid_o/s_awvalid_o asserted exactly 1 cycle after master handshake.

Reset
REQ-028 rst_n=0 at clk edge SHALL force both FSMs to IDLE, last-grant pointers to M1 (M0 wins first tie), latched id/addr to 0.
REQ-029 During and one cycle after reset assertion all valid/ready outputs SHALL be 0; in-flight transactions are abandoned, not replayed.

Verification
REQ-030 rst_n low 2 cycles with m0_arvalid_i=1 -> all valid/ready outputs 0; first cycle after release m0_arready_o=1.
REQ-031 M0 read id 3, addr 0x1040 -> next cycle s_arid_o=3, s_araddr_o=0x1040; slave data 0xA5.. reaches m0_rdata_o with m0_rvalid_o=1; m1_rvalid_o stays 0.
REQ-032 M0 and M1 arvalid same cycle, repeated 4 times -> grant order M0, M1, M0, M1.
REQ-033 M1 write id 5, addr 0x2000, data 0x1234.. -> s_awaddr_o=0x2000, s_wid_o=5, s_wdata_o matches; m1_bvalid_o with m1_bid_o=5; m0_bvalid_o 0.
REQ-034 M0 read and M1 write issued same cycle -> both complete, neither path waits on the other.
REQ-035 m0_rready_i low 3 cycles with s_rvalid_i=1 -> s_rready_o=0, FSM stays R_DATA, m0_rdata_o stable; completes on rready.
